// File: rtl/golomb_pkg.sv
// Shared types and constants for the Golomb-Rice stream controller and its decode datapath.
package golomb_pkg;
    localparam int SYM_W   = 9;
    localparam int M_W     = 3;
    localparam int BUF_W   = 64;
    localparam int LEN_W   = 6;
    localparam int MAX_LEN = 32;
    localparam int BCNT_W  = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        DECODE = 3'd2,
        EMIT   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    function automatic logic len_ok(input logic [LEN_W-1:0] len);
        return (len != {LEN_W{1'b0}}) && (len <= LEN_W'(MAX_LEN));
    endfunction
endpackage

// File: rtl/golomb_stream_ctrl_if.sv
// Word-in, decoder request/response and symbol-out signals of the stream controller.
interface golomb_stream_ctrl_if #(
    parameter int WORD_W = 32,
    parameter int SYM_W  = 9
);
    logic [WORD_W-1:0]             word_in;
    logic                          word_valid;
    logic                          word_ready;
    logic [WORD_W-1:0]             dec_window;
    logic [golomb_pkg::M_W-1:0]    dec_m;
    logic                          dec_valid;
    logic                          dec_done;
    logic [SYM_W-1:0]              dec_n;
    logic [golomb_pkg::LEN_W-1:0]  dec_len;
    logic [SYM_W-1:0]              sym_out;
    logic                          sym_valid;
    logic                          sym_ready;

    modport master (
        input  word_in, word_valid, dec_done, dec_n, dec_len, sym_ready,
        output word_ready, dec_window, dec_m, dec_valid, sym_out, sym_valid
    );

    modport slave (
        output word_in, word_valid, dec_done, dec_n, dec_len, sym_ready,
        input  word_ready, dec_window, dec_m, dec_valid, sym_out, sym_valid
    );
endinterface

// File: rtl/golomb_bitbuf.sv
// MSB-first 64-bit bit buffer: loads a word at the current fill level and
// shifts out consumed codeword bits with zero fill.
module golomb_bitbuf
    import golomb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_clr,
    input  logic                 i_load,
    input  logic [BUF_W/2-1:0]   i_word,
    input  logic                 i_shift,
    input  logic [LEN_W-1:0]     i_len,
    output logic [BUF_W/2-1:0]   o_window,
    output logic [BCNT_W-1:0]    o_cnt,
    output logic [BCNT_W-1:0]    o_cnt_nxt
);
    logic [BUF_W-1:0]  r_buf;
    logic [BUF_W-1:0]  w_buf_nxt;
    logic [BCNT_W-1:0] r_cnt;
    logic [BCNT_W-1:0] w_cnt_nxt;

    // Next contents; bits below the fill level are always zero, so OR-ing in a word writes it.
    always_comb begin
        w_buf_nxt = r_buf;
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_buf_nxt = {BUF_W{1'b0}};
            w_cnt_nxt = {BCNT_W{1'b0}};
        end else if (i_load) begin
            w_buf_nxt = r_buf | ({i_word, {(BUF_W/2){1'b0}}} >> r_cnt);
            w_cnt_nxt = r_cnt + BCNT_W'(BUF_W/2);
        end else if (i_shift) begin
            w_buf_nxt = r_buf << i_len;
            w_cnt_nxt = r_cnt - BCNT_W'(i_len);
        end else begin
            w_buf_nxt = r_buf;
            w_cnt_nxt = r_cnt;
        end
    end

    // Buffer and fill-level registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf <= {BUF_W{1'b0}};
            r_cnt <= {BCNT_W{1'b0}};
        end else begin
            r_buf <= w_buf_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_window  = r_buf[BUF_W-1 -: BUF_W/2];
    assign o_cnt     = r_cnt;
    assign o_cnt_nxt = w_cnt_nxt;
endmodule

// File: rtl/golomb_stream_ctrl.sv
// Sequencer that refills the bit buffer from packed words, hands 32-bit windows
// to the Golomb-Rice decoder and forwards the decoded symbols downstream.
module golomb_stream_ctrl
    import golomb_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16,
    parameter int SYM_W  = golomb_pkg::SYM_W
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [M_W-1:0]      m_cfg,
    input  logic [CNT_W-1:0]    sym_count,
    golomb_stream_ctrl_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                err
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [M_W-1:0]     r_m;
    logic [CNT_W-1:0]   r_remaining;
    logic [SYM_W-1:0]   r_sym;
    logic               r_word_ready;
    logic               r_dec_valid;
    logic               r_sym_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_word_ready_nxt;
    logic               w_dec_valid_nxt;
    logic               w_sym_valid_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;

    logic               w_start_ok;
    logic               w_accept;
    logic               w_dec_fire;
    logic               w_len_ok;
    logic               w_sym_fire;
    logic [WORD_W-1:0]  w_window;
    logic [BCNT_W-1:0]  w_bit_cnt;
    logic [BCNT_W-1:0]  w_bit_cnt_nxt;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == ERR));
    assign w_accept   = bus.word_valid && r_word_ready;
    assign w_dec_fire = (r_state == DECODE) && bus.dec_done;
    assign w_len_ok   = len_ok(bus.dec_len);
    assign w_sym_fire = r_sym_valid && bus.sym_ready;

    golomb_bitbuf u_bitbuf (
        .clk       (clk),
        .rstn      (rstn),
        .i_clr     (w_start_ok || (r_state == DONE)),
        .i_load    (w_accept),
        .i_word    (bus.word_in),
        .i_shift   (w_dec_fire && w_len_ok),
        .i_len     (bus.dec_len),
        .o_window  (w_window),
        .o_cnt     (w_bit_cnt),
        .o_cnt_nxt (w_bit_cnt_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, ERR: begin
                if (start) begin
                    w_state_nxt = (sym_count == {CNT_W{1'b0}}) ? DONE : FILL;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            FILL: begin
                if (w_bit_cnt >= BCNT_W'(MAX_LEN)) begin
                    w_state_nxt = DECODE;
                end else begin
                    w_state_nxt = FILL;
                end
            end
            DECODE: begin
                if (bus.dec_done) begin
                    w_state_nxt = w_len_ok ? EMIT : ERR;
                end else begin
                    w_state_nxt = DECODE;
                end
            end
            EMIT: begin
                if (w_sym_fire) begin
                    w_state_nxt = (r_remaining == CNT_W'(1)) ? DONE : FILL;
                end else begin
                    w_state_nxt = EMIT;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        w_busy_nxt       = (w_state_nxt != IDLE);
        w_done_nxt       = (w_state_nxt == DONE);
        w_err_nxt        = (w_state_nxt == ERR);
        w_dec_valid_nxt  = (w_state_nxt == DECODE);
        w_sym_valid_nxt  = (w_state_nxt == EMIT);
        w_word_ready_nxt = (w_state_nxt == FILL) && (w_bit_cnt_nxt < BCNT_W'(MAX_LEN));
    end

    // Output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_dec_valid  <= 1'b0;
            r_sym_valid  <= 1'b0;
            r_word_ready <= 1'b0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_dec_valid  <= w_dec_valid_nxt;
            r_sym_valid  <= w_sym_valid_nxt;
            r_word_ready <= w_word_ready_nxt;
        end
    end

    // Block configuration, symbol countdown and decoded symbol holding register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m         <= {M_W{1'b0}};
            r_remaining <= {CNT_W{1'b0}};
            r_sym       <= {SYM_W{1'b0}};
        end else begin
            if (w_start_ok) begin
                r_m         <= m_cfg;
                r_remaining <= sym_count;
            end else if (w_sym_fire) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end else begin
                r_remaining <= r_remaining;
            end
            if (w_dec_fire && w_len_ok) begin
                r_sym <= bus.dec_n;
            end else begin
                r_sym <= r_sym;
            end
        end
    end

    assign bus.word_ready = r_word_ready;
    assign bus.dec_window = w_window;
    assign bus.dec_m      = r_m;
    assign bus.dec_valid  = r_dec_valid;
    assign bus.sym_out    = r_sym;
    assign bus.sym_valid  = r_sym_valid;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
endmodule

// File: tb/tb_golomb_stream_ctrl.sv
// Self-checking bench: symbols are generated first, Rice-encoded into a word
// stream, and the controller's windows and outputs are checked against that list.
module tb_golomb_stream_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  m_cfg = 3'd0;
    logic [15:0] sym_count = 16'd0;
    logic        busy, done, err;

    golomb_stream_ctrl_if #(.WORD_W(32), .SYM_W(9)) bus ();

    golomb_stream_ctrl #(.WORD_W(32), .CNT_W(16), .SYM_W(9)) dut (
        .clk(clk), .rstn(rstn), .start(start), .m_cfg(m_cfg), .sym_count(sym_count),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned words[$];
    int exp_n[$];
    int exp_len[$];

    typedef struct {
        int m; int cnt; bit nominal; bit starve; int stall; bit bp; int exp_words;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] window_at(input int p);
        logic [31:0] w;
        int unsigned wd;
        w = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((p + i) / 32 < words.size()) begin
                wd = words[(p + i) / 32];
                w[31 - i] = wd[31 - ((p + i) % 32)];
            end
        end
        return w;
    endfunction

    task automatic build_nominal();
        words = '{32'h1A1C1009, 32'h0000_0000};
        exp_n = '{29, 38, 40, 33};
        exp_len = '{7, 8, 9, 8};
    endtask

    // Random symbols for parameter m, Rice-encoded (unary zeros, a one, m remainder bits).
    task automatic build_random(input int m, input int cnt);
        bit bits[$];
        int q, r, qmax;
        int unsigned w;
        words.delete(); exp_n.delete(); exp_len.delete();
        qmax = (511 - ((1 << m) - 1)) >> m;
        if (qmax > 31 - m) qmax = 31 - m;
        for (int s = 0; s < cnt; s++) begin
            q = ($urandom_range(0, 3) == 0) ? qmax : int'($urandom_range(0, qmax));
            r = int'($urandom_range(0, (1 << m) - 1));
            exp_n.push_back((q << m) | r);
            exp_len.push_back(q + 1 + m);
            for (int i = 0; i < q; i++) bits.push_back(1'b0);
            bits.push_back(1'b1);
            for (int i = m - 1; i >= 0; i--) bits.push_back(r[i]);
        end
        for (int k = 0; k < (bits.size() + 31) / 32 + 1; k++) begin
            w = 32'd0;
            for (int i = 0; i < 32; i++)
                if (k * 32 + i < bits.size()) w[31 - i] = bits[k * 32 + i];
            words.push_back(w);
        end
    endtask

    task automatic idle_inputs();
        bus.word_valid = 1'b0; bus.word_in = 32'd0;
        bus.dec_done = 1'b0; bus.dec_n = 9'd0; bus.dec_len = 6'd0;
        bus.sym_ready = 1'b0;
    endtask

    // Runs one block from start to done; entered and left at #1 after a rising edge.
    task automatic run_block(input int m, input int cnt, input bit starve, input int stall,
                             input bit bp, input int exp_words);
        int widx, pos, kd, ks, dwait, stall_left, done_cnt, done_cyc, cyc;
        bit dv_seen, acc, dfire, sfire;
        widx = 0; pos = 0; kd = 0; ks = 0; dwait = 0; stall_left = stall;
        done_cnt = 0; done_cyc = -1; dv_seen = 1'b0;
        m_cfg = m[2:0]; sym_count = cnt[15:0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_err_clear", err, 1'b0);
        check("start_busy", busy, 1'b1);
        for (cyc = 0; cyc < 1500; cyc++) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            bus.word_valid = (widx < words.size()) && (!starve || (cyc % 2 == 0));
            bus.word_in = bus.word_valid ? words[widx] : $urandom;
            acc = bus.word_valid && bus.word_ready;
            bus.dec_done = 1'b0; bus.dec_n = 9'($urandom); bus.dec_len = 6'($urandom);
            dfire = 1'b0;
            if (bus.dec_valid) begin
                check("dec_window", bus.dec_window, window_at(pos));
                check("dec_m", bus.dec_m, m[2:0]);
                if (!dv_seen) begin
                    dv_seen = 1'b1;
                    dwait = int'($urandom_range(0, 2));
                    check("fill_level_ge32", (32 * widx - pos) >= 32, 1'b1);
                end
                if (dwait == 0) begin
                    if (kd < exp_n.size()) begin
                        bus.dec_done = 1'b1; bus.dec_n = exp_n[kd][8:0]; bus.dec_len = exp_len[kd][5:0];
                        dfire = 1'b1;
                    end
                end else begin
                    dwait--;
                end
            end
            bus.sym_ready = 1'b0; sfire = 1'b0;
            if (bus.sym_valid) begin
                if (ks < exp_n.size()) check("sym_out", bus.sym_out, exp_n[ks][8:0]);
                else check("extra_symbol", 1'b1, 1'b0);
                if (ks == 0 && stall_left > 0) begin
                    stall_left--;
                    check("stall_no_dec_valid", bus.dec_valid, 1'b0);
                    check("stall_no_word_ready", bus.word_ready, 1'b0);
                end else if (!bp || $urandom_range(0, 2) != 0) begin
                    bus.sym_ready = 1'b1; sfire = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (acc) widx++;
            if (dfire) begin pos += exp_len[kd]; kd++; dv_seen = 1'b0; end
            if (sfire) ks++;
        end
        idle_inputs();
        check("block_done_seen", done_cyc >= 0, 1'b1);
        check("done_pulses", done_cnt, 1);
        check("symbols_emitted", ks, cnt);
        check("decode_requests", kd, cnt);
        check("end_err", err, 1'b0);
        check("end_busy", busy, 1'b0);
        check("end_window_cleared", bus.dec_window, 32'd0);
        if (exp_words >= 0) check("words_consumed", widx, exp_words);
        if (cnt == 0) check("empty_done_latency", done_cyc <= 1, 1'b1);
    endtask

    // Bad decoder length on the first request must latch err until the next start.
    task automatic bad_len(input int blen);
        int widx;
        bit got, acc;
        widx = 0; got = 1'b0;
        build_nominal();
        m_cfg = 3'd3; sym_count = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            bus.word_valid = (widx < words.size());
            bus.word_in = bus.word_valid ? words[widx] : 32'd0;
            acc = bus.word_valid && bus.word_ready;
            if (bus.dec_valid) begin
                bus.dec_done = 1'b1; bus.dec_n = 9'd5; bus.dec_len = blen[5:0]; got = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) widx++;
        end
        idle_inputs();
        check("badlen_request_seen", got, 1'b1);
        check("badlen_err", err, 1'b1);
        check("badlen_busy", busy, 1'b1);
        check("badlen_no_sym", bus.sym_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("badlen_err_sticky", err, 1'b1);
            check("badlen_no_dec_valid", bus.dec_valid, 1'b0);
            check("badlen_no_word_ready", bus.word_ready, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word_ready"}, bus.word_ready, 1'b0);
        check({tag, "_dec_valid"}, bus.dec_valid, 1'b0);
        check({tag, "_dec_window"}, bus.dec_window, 32'd0);
        check({tag, "_dec_m"}, bus.dec_m, 3'd0);
        check({tag, "_sym_out"}, bus.sym_out, 9'd0);
        check({tag, "_sym_valid"}, bus.sym_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    // Asynchronous reset while a decode request is outstanding.
    task automatic reset_mid_decode();
        int widx;
        bit got, acc;
        widx = 0; got = 1'b0;
        build_nominal();
        m_cfg = 3'd3; sym_count = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            if (bus.dec_valid) begin
                got = 1'b1;
            end else begin
                bus.word_valid = (widx < words.size());
                bus.word_in = bus.word_valid ? words[widx] : 32'd0;
                acc = bus.word_valid && bus.word_ready;
                @(posedge clk); #1;
                if (acc) widx++;
            end
        end
        idle_inputs();
        check("rst_request_seen", got, 1'b1);
        #2 rstn = 1'b0;
        #1 check_all_zero("rst_async");
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        bus.word_valid = 1'b1; bus.word_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            check("rst_idle_no_ready", bus.word_ready, 1'b0);
            check("rst_idle_busy", busy, 1'b0);
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        vecs[0] = '{3, 4, 1'b1, 1'b0, 0, 1'b0, 2};
        vecs[1] = '{3, 4, 1'b1, 1'b0, 5, 1'b0, 2};
        vecs[2] = '{3, 4, 1'b1, 1'b1, 0, 1'b0, 2};
        vecs[3] = '{3, 0, 1'b0, 1'b0, 0, 1'b0, 0};
        vecs[4] = '{0, 12, 1'b0, 1'b0, 0, 1'b1, -1};
        vecs[5] = '{7, 10, 1'b0, 1'b1, 2, 1'b1, -1};
        for (int i = 6; i < 10; i++)
            vecs[i] = '{int'($urandom_range(0, 7)), int'($urandom_range(1, 12)), 1'b0,
                        1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1, -1};

        #3 check_all_zero("reset");
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].nominal) build_nominal();
            else build_random(vecs[i].m, vecs[i].cnt);
            run_block(vecs[i].m, vecs[i].cnt, vecs[i].starve, vecs[i].stall, vecs[i].bp, vecs[i].exp_words);
        end

        bad_len(0);
        build_nominal();
        run_block(3, 4, 1'b0, 0, 1'b0, 2);
        bad_len(40);
        build_random(5, 6);
        run_block(5, 6, 1'b0, 0, 1'b1, -1);

        reset_mid_decode();
        build_nominal();
        run_block(3, 4, 1'b0, 0, 1'b0, 2);

        for (int b = 0; b < 15; b++) begin
            int m, cnt;
            m = int'($urandom_range(0, 7));
            cnt = int'($urandom_range(1, 16));
            build_random(m, cnt);
            run_block(m, cnt, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
